// File: rtl/pong_meas_pkg.sv
// Shared definitions for the pong measurement blocks.
//   meter_state_e       : state encoding of the strobe frequency meter
//   GATE_CYCLES_DEFAULT : one-second gate window in board clock cycles
`ifndef BOARD_CLK_MHZ
`define BOARD_CLK_MHZ 100
`endif

package pong_meas_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  localparam int unsigned GATE_CYCLES_DEFAULT = `BOARD_CLK_MHZ * 1_000_000;

endpackage

// File: rtl/strobe_edge_det.sv
// Rising-edge detector for a clk_i-synchronous level (strobes, buttons).
// The previous level is held in a register that updates every cycle, so a
// level that is already high only produces a new edge after it falls.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   d_i    : level to watch
//   rise_o : high in the cycle where d_i is 1 and was 0 the cycle before
module strobe_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q_r;

  // Previous-cycle copy of the watched level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q_r <= 1'b0;
    end else begin
      d_q_r <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q_r;

endmodule

// File: rtl/strobe_freq_meter.sv
// Strobe frequency meter: counts rising edges of strobe_i over a gate
// window of GATE_CYCLES clocks and publishes the count on freq_o, in the
// same units dynamic_strobe_gen takes as its strobe frequency.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   en_i         : measure continuously while high
//   strobe_i     : strobe to measure (synchronous, any pulse width)
//   freq_o       : edge count of the last completed window
//   freq_valid_o : one-cycle pulse when freq_o updates
//   overflow_o   : last completed window saturated the count
//   busy_o       : a window is in progress
module strobe_freq_meter
  import pong_meas_pkg::*;
#(
  parameter int FREQ_W      = 10,
  parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int GATE_W      = $clog2(GATE_CYCLES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              strobe_i,
  output logic [FREQ_W-1:0] freq_o,
  output logic              freq_valid_o,
  output logic              overflow_o,
  output logic              busy_o
);

  localparam logic [FREQ_W-1:0] EVT_MAX   = {FREQ_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  meter_state_e      state_r, state_next_s;
  logic [GATE_W-1:0] gate_cnt_r, gate_cnt_next_s;
  logic [FREQ_W-1:0] evt_cnt_r, evt_cnt_next_s, evt_inc_s;
  logic              ovf_r, ovf_next_s, ovf_inc_s;
  logic              rise_s, last_gate_s, load_s;

  logic [FREQ_W-1:0] freq_r;
  logic              freq_valid_r, overflow_r, busy_r;

  strobe_edge_det u_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (strobe_i),
    .rise_o (rise_s)
  );

  // Event count and overflow flag including this cycle's edge (saturating).
  always_comb begin
    evt_inc_s = evt_cnt_r;
    ovf_inc_s = ovf_r;
    if (rise_s) begin
      if (evt_cnt_r == EVT_MAX) begin
        ovf_inc_s = 1'b1;
      end else begin
        evt_inc_s = evt_cnt_r + FREQ_W'(1'b1);
      end
    end else begin
      evt_inc_s = evt_cnt_r;
    end
  end

  assign last_gate_s = (gate_cnt_r == GATE_LAST);

  // Next-state logic: window sequencing, abort and back-to-back restart.
  always_comb begin
    state_next_s    = state_r;
    gate_cnt_next_s = gate_cnt_r;
    evt_cnt_next_s  = evt_cnt_r;
    ovf_next_s      = ovf_r;
    load_s          = 1'b0;
    case (state_r)
      IDLE: begin
        gate_cnt_next_s = {GATE_W{1'b0}};
        evt_cnt_next_s  = {FREQ_W{1'b0}};
        ovf_next_s      = 1'b0;
        if (en_i) begin
          state_next_s = MEASURE;
        end else begin
          state_next_s = IDLE;
        end
      end
      MEASURE: begin
        if (last_gate_s) begin
          // Window complete; a new one starts next cycle if still enabled.
          load_s          = 1'b1;
          gate_cnt_next_s = {GATE_W{1'b0}};
          evt_cnt_next_s  = {FREQ_W{1'b0}};
          ovf_next_s      = 1'b0;
          state_next_s    = en_i ? MEASURE : IDLE;
        end else if (!en_i) begin
          // Abort: the partial count is dropped, outputs keep old values.
          gate_cnt_next_s = {GATE_W{1'b0}};
          evt_cnt_next_s  = {FREQ_W{1'b0}};
          ovf_next_s      = 1'b0;
          state_next_s    = IDLE;
        end else begin
          gate_cnt_next_s = gate_cnt_r + GATE_W'(1'b1);
          evt_cnt_next_s  = evt_inc_s;
          ovf_next_s      = ovf_inc_s;
          state_next_s    = MEASURE;
        end
      end
      default: begin
        gate_cnt_next_s = {GATE_W{1'b0}};
        evt_cnt_next_s  = {FREQ_W{1'b0}};
        ovf_next_s      = 1'b0;
        state_next_s    = IDLE;
      end
    endcase
  end

  // State and window counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      gate_cnt_r <= {GATE_W{1'b0}};
      evt_cnt_r  <= {FREQ_W{1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      gate_cnt_r <= gate_cnt_next_s;
      evt_cnt_r  <= evt_cnt_next_s;
      ovf_r      <= ovf_next_s;
    end
  end

  // Registered result, valid pulse and busy flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      freq_r       <= {FREQ_W{1'b0}};
      overflow_r   <= 1'b0;
      freq_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (load_s) begin
        freq_r     <= evt_inc_s;
        overflow_r <= ovf_inc_s;
      end else begin
        freq_r     <= freq_r;
        overflow_r <= overflow_r;
      end
      freq_valid_r <= load_s;
      busy_r       <= (state_next_s == MEASURE);
    end
  end

  assign freq_o       = freq_r;
  assign overflow_o   = overflow_r;
  assign freq_valid_o = freq_valid_r;
  assign busy_o       = busy_r;

endmodule
